tile_energy_accum_mc: RTL and testbench



---
 rtl/tile_energy_accum_mc_if.sv | 38 +++
 rtl/tile_energy_accum_mc.sv | 246 ++++++++++++++++++++++++
 tb/tb_tile_energy_accum_mc.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/tile_energy_accum_mc_if.sv
// Bundle of the energy integrator's telemetry inputs, control and readout.
// The master side drives telemetry and control; the slave is the integrator.
interface tile_energy_accum_mc_if #(
    parameter int NUM_CH = 4,
    parameter int ACC_W  = 64,
    parameter int WIN_W  = 32
);
    localparam int RD_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [11:0]          freq_mhz;
    logic [NUM_CH*16-1:0] dyn_pwr_mw;
    logic [NUM_CH*16-1:0] leak_pwr_mw;
    logic [NUM_CH-1:0]    ch_en;
    logic                 clear;
    logic [WIN_W-1:0]     budget_pj;
    logic [RD_W-1:0]      rd_ch;

    logic [ACC_W-1:0]     rd_total_pj;
    logic [ACC_W-1:0]     rd_dyn_pj;
    logic [ACC_W-1:0]     rd_leak_pj;
    logic [WIN_W-1:0]     rd_win_pj;
    logic [19:0]          period_ps;
    logic                 period_valid;
    logic                 window_done;
    logic [NUM_CH-1:0]    over_budget;

    modport master (
        output freq_mhz, dyn_pwr_mw, leak_pwr_mw, ch_en, clear, budget_pj, rd_ch,
        input  rd_total_pj, rd_dyn_pj, rd_leak_pj, rd_win_pj,
               period_ps, period_valid, window_done, over_budget
    );

    modport slave (
        input  freq_mhz, dyn_pwr_mw, leak_pwr_mw, ch_en, clear, budget_pj, rd_ch,
        output rd_total_pj, rd_dyn_pj, rd_leak_pj, rd_win_pj,
               period_ps, period_valid, window_done, over_budget
    );
endinterface

// File: rtl/tile_energy_accum_mc.sv
// Multi-channel picojoule integrator: converts per-domain mW telemetry and the
// DVFS frequency into saturating lifetime and windowed energy accumulators.
//
// Divider FSM
//   state    | meaning
//   DIV_IDLE | period_ps/period_valid stable, waiting for a frequency change
//   DIV_RUN  | 20 restoring iterations of 1_000_000 / freq_mhz, old period held
//   DIV_DONE | quotient ready, committed to period_ps on this edge
module tile_energy_accum_mc #(
    parameter int NUM_CH        = 4,
    parameter int ACC_W         = 64,
    parameter int WIN_W         = 32,
    parameter int WINDOW_CYCLES = 1024
) (
    input logic                    clk,
    input logic                    reset,
    tile_energy_accum_mc_if.slave  bus
);
    // 17-bit power sum times 20-bit period
    localparam int PROD_W  = 37;
    localparam int SUM_A_W = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam int SUM_W_W = ((WIN_W > PROD_W) ? WIN_W : PROD_W) + 1;
    localparam int CNT_W   = $clog2(WINDOW_CYCLES);
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [19:0]      DIVIDEND = 20'd1_000_000;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    div_state_t  div_state, div_state_d;
    logic [4:0]  div_cnt, div_cnt_d;
    logic [12:0] div_rem, div_rem_d;
    logic [19:0] div_quo, div_quo_d;
    logic [11:0] div_dsr, div_dsr_d;
    logic [11:0] last_freq;
    logic        first_q;
    logic [19:0] period_q, period_d;
    logic        valid_q, valid_d;
    logic        div_start;
    logic [13:0] trial;
    logic        trial_ge;
    logic [12:0] trial_sub;

    logic [ACC_W-1:0]  acc_dyn [NUM_CH];
    logic [ACC_W-1:0]  acc_leak[NUM_CH];
    logic [ACC_W-1:0]  acc_tot [NUM_CH];
    logic [WIN_W-1:0]  win_acc [NUM_CH];
    logic [WIN_W-1:0]  win_last[NUM_CH];
    logic [NUM_CH-1:0] over_q;
    logic [CNT_W-1:0]  win_cnt;
    logic              done_q;

    logic [PROD_W-1:0] inc_d[NUM_CH];
    logic [PROD_W-1:0] inc_l[NUM_CH];
    logic [PROD_W-1:0] inc_t[NUM_CH];
    logic [ACC_W-1:0]  dyn_d [NUM_CH];
    logic [ACC_W-1:0]  leak_d[NUM_CH];
    logic [ACC_W-1:0]  tot_d [NUM_CH];
    logic [WIN_W-1:0]  wsum  [NUM_CH];
    logic [WIN_W-1:0]  wacc_d[NUM_CH];
    logic [WIN_W-1:0]  wlast_d[NUM_CH];
    logic [NUM_CH-1:0] over_d;
    logic [CNT_W-1:0]  cnt_d;
    logic              accum, close;

    logic [ACC_W-1:0]  rd_tot_q, rd_dyn_q, rd_leak_q;
    logic [WIN_W-1:0]  rd_win_q;

    function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] a,
                                                 input logic [PROD_W-1:0] b);
        logic [SUM_A_W-1:0] s;
        s = SUM_A_W'(a) + SUM_A_W'(b);
        if (s > SUM_A_W'({ACC_W{1'b1}})) return {ACC_W{1'b1}};
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [WIN_W-1:0] sat_win(input logic [WIN_W-1:0] a,
                                                 input logic [PROD_W-1:0] b);
        logic [SUM_W_W-1:0] s;
        s = SUM_W_W'(a) + SUM_W_W'(b);
        if (s > SUM_W_W'({WIN_W{1'b1}})) return {WIN_W{1'b1}};
        return s[WIN_W-1:0];
    endfunction

    // Divider state and period registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_state <= DIV_IDLE;
            div_cnt   <= '0;
            div_rem   <= '0;
            div_quo   <= '0;
            div_dsr   <= '0;
            last_freq <= '0;
            first_q   <= 1'b1;
            period_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            div_state <= div_state_d;
            div_cnt   <= div_cnt_d;
            div_rem   <= div_rem_d;
            div_quo   <= div_quo_d;
            div_dsr   <= div_dsr_d;
            last_freq <= bus.freq_mhz;
            first_q   <= 1'b0;
            period_q  <= period_d;
            valid_q   <= valid_d;
        end
    end

    // Divider next state; a new start always aborts a division in flight
    always_comb begin
        div_state_d = div_state;
        div_cnt_d   = div_cnt;
        div_rem_d   = div_rem;
        div_quo_d   = div_quo;
        div_dsr_d   = div_dsr;
        period_d    = period_q;
        valid_d     = valid_q;
        div_start   = first_q || (bus.freq_mhz != last_freq);
        trial       = {div_rem, div_quo[19]};
        trial_ge    = (trial >= {2'b00, div_dsr});
        // when trial >= divisor the difference is below the divisor, so 13 bits hold it
        trial_sub   = trial[12:0] - {1'b0, div_dsr};
        if (div_start) begin
            if (bus.freq_mhz == 12'd0) begin
                div_state_d = DIV_IDLE;
                period_d    = '0;
                valid_d     = 1'b0;
            end else begin
                div_state_d = DIV_RUN;
                div_cnt_d   = '0;
                div_rem_d   = '0;
                div_quo_d   = DIVIDEND;
                div_dsr_d   = bus.freq_mhz;
            end
        end else begin
            case (div_state)
                DIV_RUN: begin
                    div_rem_d = trial_ge ? trial_sub : trial[12:0];
                    div_quo_d = {div_quo[18:0], trial_ge};
                    div_cnt_d = div_cnt + 5'd1;
                    if (div_cnt == 5'd19) div_state_d = DIV_DONE;
                end
                DIV_DONE: begin
                    period_d    = div_quo;
                    valid_d     = 1'b1;
                    div_state_d = DIV_IDLE;
                end
                default: ;
            endcase
        end
    end

    // Per-channel increments, zero for disabled channels or when not accumulating;
    // the total is truncated on its own so it matches the reference model
    always_comb begin
        accum = valid_q && !bus.clear;
        close = accum && (win_cnt == WIN_LAST);
        for (int i = 0; i < NUM_CH; i++) begin
            inc_d[i] = (PROD_W'(bus.dyn_pwr_mw[16*i +: 16]) * PROD_W'(period_q))
                       / PROD_W'(1000);
            inc_l[i] = (PROD_W'(bus.leak_pwr_mw[16*i +: 16]) * PROD_W'(period_q))
                       / PROD_W'(1000);
            inc_t[i] = ((PROD_W'(bus.dyn_pwr_mw[16*i +: 16])
                         + PROD_W'(bus.leak_pwr_mw[16*i +: 16])) * PROD_W'(period_q))
                       / PROD_W'(1000);
            if (!(accum && bus.ch_en[i])) begin
                inc_d[i] = '0;
                inc_l[i] = '0;
                inc_t[i] = '0;
            end
        end
    end

    // Next accumulator and window state; clear wins over accumulate and window close
    always_comb begin
        over_d = over_q;
        cnt_d  = win_cnt;
        for (int i = 0; i < NUM_CH; i++) begin
            dyn_d[i]   = sat_acc(acc_dyn[i],  inc_d[i]);
            leak_d[i]  = sat_acc(acc_leak[i], inc_l[i]);
            tot_d[i]   = sat_acc(acc_tot[i],  inc_t[i]);
            wsum[i]    = sat_win(win_acc[i],  inc_t[i]);
            wacc_d[i]  = wsum[i];
            wlast_d[i] = win_last[i];
            if (bus.clear) begin
                dyn_d[i]   = '0;
                leak_d[i]  = '0;
                tot_d[i]   = '0;
                wacc_d[i]  = '0;
                wlast_d[i] = '0;
                over_d[i]  = 1'b0;
            end else if (close) begin
                wacc_d[i]  = '0;
                wlast_d[i] = wsum[i];
                over_d[i]  = (wsum[i] > bus.budget_pj);
            end
        end
        if (bus.clear) cnt_d = '0;
        else if (close) cnt_d = '0;
        else if (accum) cnt_d = win_cnt + CNT_W'(1);
    end

    // Accumulator, window and readout registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_dyn[i]  <= '0;
                acc_leak[i] <= '0;
                acc_tot[i]  <= '0;
                win_acc[i]  <= '0;
                win_last[i] <= '0;
            end
            over_q    <= '0;
            win_cnt   <= '0;
            done_q    <= 1'b0;
            rd_tot_q  <= '0;
            rd_dyn_q  <= '0;
            rd_leak_q <= '0;
            rd_win_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_dyn[i]  <= dyn_d[i];
                acc_leak[i] <= leak_d[i];
                acc_tot[i]  <= tot_d[i];
                win_acc[i]  <= wacc_d[i];
                win_last[i] <= wlast_d[i];
            end
            over_q    <= over_d;
            win_cnt   <= cnt_d;
            done_q    <= close;
            rd_tot_q  <= tot_d[bus.rd_ch];
            rd_dyn_q  <= dyn_d[bus.rd_ch];
            rd_leak_q <= leak_d[bus.rd_ch];
            rd_win_q  <= wlast_d[bus.rd_ch];
        end
    end

    assign bus.rd_total_pj  = rd_tot_q;
    assign bus.rd_dyn_pj    = rd_dyn_q;
    assign bus.rd_leak_pj   = rd_leak_q;
    assign bus.rd_win_pj    = rd_win_q;
    assign bus.period_ps    = period_q;
    assign bus.period_valid = valid_q;
    assign bus.window_done  = done_q;
    assign bus.over_budget  = over_q;
endmodule

// File: tb/tb_tile_energy_accum_mc.sv
// Directed bench for tile_energy_accum_mc: a 2-channel instance with a
// 100-cycle window, and a 16-bit-accumulator instance for saturation.
module tb_tile_energy_accum_mc;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    tile_energy_accum_mc_if #(.NUM_CH(2), .ACC_W(64), .WIN_W(32)) bus_m ();
    tile_energy_accum_mc_if #(.NUM_CH(2), .ACC_W(16), .WIN_W(32)) bus_s ();

    tile_energy_accum_mc #(.NUM_CH(2), .ACC_W(64), .WIN_W(32), .WINDOW_CYCLES(100)) u_main (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_m)
    );

    tile_energy_accum_mc #(.NUM_CH(2), .ACC_W(16), .WIN_W(32), .WINDOW_CYCLES(1024)) u_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bounded wait for the main instance to publish a given period
    task automatic wait_period(input logic [19:0] target, input int max_cycles);
        int k;
        k = 0;
        while (!(bus_m.period_valid && bus_m.period_ps == target) && k < max_cycles) begin
            tick(1);
            k++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus_m.freq_mhz = 12'd0;
        bus_m.dyn_pwr_mw = '0;
        bus_m.leak_pwr_mw = '0;
        bus_m.ch_en = 2'b00;
        bus_m.clear = 1'b0;
        bus_m.budget_pj = 32'd50000;
        bus_m.rd_ch = 1'b0;
        bus_s.freq_mhz = 12'd1000;
        bus_s.dyn_pwr_mw = {16'd0, 16'd500};
        bus_s.leak_pwr_mw = '0;
        bus_s.ch_en = 2'b00;
        bus_s.clear = 1'b0;
        bus_s.budget_pj = '0;
        bus_s.rd_ch = 1'b0;
        #2 reset = 1'b1;
        tick(3);

        // reset state
        check("rst_total", bus_m.rd_total_pj, 0);
        check("rst_valid", bus_m.period_valid, 0);
        check("rst_period", bus_m.period_ps, 0);
        check("rst_wdone", bus_m.window_done, 0);
        check("rst_over", bus_m.over_budget, 0);

        // divider latency: start at edge S, period visible after S+21
        bus_m.freq_mhz = 12'd1000;
        bus_m.dyn_pwr_mw = {16'd0, 16'd500};
        bus_m.leak_pwr_mw = {16'd0, 16'd100};
        reset = 1'b0;
        tick(21);
        check("lat_valid_s20", bus_m.period_valid, 0);
        tick(1);
        check("lat_valid_s21", bus_m.period_valid, 1);
        check("lat_period_1000", bus_m.period_ps, 1000);

        // 100 accumulations at 1000 MHz: 500/100/600 per cycle
        bus_m.ch_en = 2'b01;
        tick(100);
        bus_m.ch_en = 2'b00;
        tick(2);
        check("acc100_dyn", bus_m.rd_dyn_pj, 50000);
        check("acc100_leak", bus_m.rd_leak_pj, 10000);
        check("acc100_total", bus_m.rd_total_pj, 60000);

        // 1000 -> 800 MHz: old period keeps accumulating during the division
        bus_m.freq_mhz = 12'd800;
        tick(2);
        bus_m.ch_en = 2'b01;
        tick(10);
        bus_m.ch_en = 2'b00;
        tick(2);
        check("hold_period", bus_m.period_ps, 1000);
        check("hold_valid", bus_m.period_valid, 1);
        check("hold_dyn", bus_m.rd_dyn_pj, 55000);
        check("hold_total", bus_m.rd_total_pj, 66000);
        wait_period(20'd1250, 40);
        check("period_800", bus_m.period_ps, 1250);
        bus_m.ch_en = 2'b01;
        tick(10);
        bus_m.ch_en = 2'b00;
        tick(2);
        check("f800_dyn", bus_m.rd_dyn_pj, 61250);
        check("f800_leak", bus_m.rd_leak_pj, 12250);
        check("f800_total", bus_m.rd_total_pj, 73500);

        // freq 0 gates accumulation; then 600 MHz with independent truncation
        bus_m.freq_mhz = 12'd0;
        tick(1);
        check("f0_valid", bus_m.period_valid, 0);
        bus_m.ch_en = 2'b01;
        tick(5);
        bus_m.ch_en = 2'b00;
        tick(1);
        check("f0_frozen_dyn", bus_m.rd_dyn_pj, 61250);
        bus_m.freq_mhz = 12'd600;
        bus_m.dyn_pwr_mw = {16'd0, 16'd501};
        wait_period(20'd1666, 40);
        check("period_600", bus_m.period_ps, 1666);
        bus_m.ch_en = 2'b01;
        tick(1);
        bus_m.ch_en = 2'b00;
        tick(2);
        check("f600_dyn", bus_m.rd_dyn_pj, 62084);
        check("f600_leak", bus_m.rd_leak_pj, 12416);
        check("f600_total", bus_m.rd_total_pj, 74501);

        // window: ch0 600/cycle, ch1 400/cycle, budget 50000
        bus_m.freq_mhz = 12'd1000;
        bus_m.dyn_pwr_mw = {16'd300, 16'd500};
        bus_m.leak_pwr_mw = {16'd100, 16'd100};
        wait_period(20'd1000, 40);
        check("period_back_1000", bus_m.period_ps, 1000);
        bus_m.clear = 1'b1;
        bus_m.ch_en = 2'b11;
        tick(1);
        bus_m.clear = 1'b0;
        check("clr_over", bus_m.over_budget, 0);
        tick(99);
        check("win_not_yet", bus_m.window_done, 0);
        tick(1);
        check("win_done", bus_m.window_done, 1);
        check("win_over", bus_m.over_budget, 2'b01);
        tick(1);
        check("win_done_1cyc", bus_m.window_done, 0);
        check("win_last_ch0", bus_m.rd_win_pj, 60000);
        bus_m.rd_ch = 1'b1;
        tick(1);
        check("win_last_ch1", bus_m.rd_win_pj, 40000);

        // clear on the closing edge of the next window wins
        tick(97);
        bus_m.clear = 1'b1;
        bus_m.ch_en = 2'b00;
        tick(1);
        bus_m.clear = 1'b0;
        check("clrwin_done", bus_m.window_done, 0);
        check("clrwin_over", bus_m.over_budget, 0);
        tick(1);
        check("clrwin_done2", bus_m.window_done, 0);
        check("clrwin_total", bus_m.rd_total_pj, 0);
        check("clrwin_last", bus_m.rd_win_pj, 0);

        // 16-bit accumulator saturates at 65535 and holds
        bus_s.ch_en = 2'b01;
        tick(131);
        bus_s.ch_en = 2'b00;
        tick(2);
        check("sat_131", bus_s.rd_dyn_pj, 65500);
        bus_s.ch_en = 2'b01;
        tick(1);
        bus_s.ch_en = 2'b00;
        tick(2);
        check("sat_132", bus_s.rd_dyn_pj, 65535);
        bus_s.ch_en = 2'b01;
        tick(10);
        bus_s.ch_en = 2'b00;
        tick(2);
        check("sat_hold_dyn", bus_s.rd_dyn_pj, 65535);
        check("sat_hold_total", bus_s.rd_total_pj, 65535);

        // reset in the middle of a division, then the period is recomputed
        bus_m.freq_mhz = 12'd700;
        tick(5);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", bus_m.period_valid, 0);
        check("mid_rst_period", bus_m.period_ps, 0);
        check("mid_rst_total", bus_m.rd_total_pj, 0);
        tick(1);
        reset = 1'b0;
        tick(21);
        check("rst_lat_s20", bus_m.period_valid, 0);
        tick(1);
        check("rst_lat_s21", bus_m.period_valid, 1);
        check("period_700", bus_m.period_ps, 1428);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
